fp_addsub_pipe: RTL
===================

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, meaning stored fraction width; the word width is W = 1+EXP_W+MAN_W, 32 by default.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operand set present.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts an operand set this cycle.
REQ-007 SHALL have port op_sub, input, 1 bit: 0 selects a+b, 1 selects a-b.
REQ-008 SHALL have port a, input, W bits: operand A, IEEE-754 style {sign, exponent, fraction}.
REQ-009 SHALL have port b, input, W bits: operand B, same format as a.
REQ-010 SHALL have port out_valid, output, 1 bit: result present.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port out, output, W bits: result word.
REQ-013 SHALL have port flags, output, 4 bits: {invalid, overflow, underflow, inexact}, qualified by out_valid.

Function
REQ-014 SHALL use a 4-stage pipeline:
- S1: unpack, operand swap so |A|>=|B|, exponent difference, effective operation = sign_a XOR sign_b XOR op_sub.
- S2: align smaller mantissa with guard/round/sticky bits, then add or subtract.
- S3: leading-zero count and normalise, exponent adjust.
- S4: round-to-nearest-even and pack.
REQ-015 SHALL accept an operand set on a cycle where in_valid && in_ready.
REQ-016 SHALL present the result exactly 4 cycles after acceptance when out_ready is held high.
REQ-017 SHALL use a global stall: stall = out_valid && !out_ready; while stalled every stage register and out/flags SHALL hold their values.
REQ-018 SHALL drive in_ready = !stall.
REQ-019 SHALL support back-to-back throughput of one operation per cycle, with each stage's valid bit advancing with its data.
REQ-020 SHALL hold out and flags stable while out_valid && !out_ready.
REQ-021 SHALL shift the aligned mantissa by at most MAN_W+3 positions; larger exponent differences SHALL fold all of B into sticky.
REQ-022 SHALL treat subnormal inputs (exponent 0) as signed zero, and SHALL flush subnormal results to signed zero with underflow=1 and inexact=1.
REQ-023 SHALL produce +0 (all-zero word) for an exact-zero result from an effective subtraction; -0 SHALL result only from (-0)+(-0) or (-0)-(+0).
REQ-024 SHALL, when either operand is NaN, produce the canonical quiet NaN {0, all-ones exponent, 1 followed by zeros} with invalid=0 if that NaN is quiet and invalid=1 if it is signalling.
REQ-025 SHALL produce inf-inf (effective subtraction) as canonical NaN with invalid=1.
REQ-026 SHALL produce inf plus a finite operand as that inf, with no flags set.
REQ-027 SHALL produce ±inf with overflow=1 and inexact=1 when the rounded exponent reaches all-ones.
REQ-028 SHALL set inexact when any guard, round or sticky bit is nonzero before rounding.
REQ-029 SHALL renormalise by one position with exponent+1 when a rounding carry overflows the mantissa.
REQ-030 SHALL produce a result identical to IEEE-754 round-to-nearest-even for all normal operands.

Reset
REQ-031 SHALL, while rst=1, clear all stage valid bits, out_valid=0, out=0, flags=0, and in_ready=1, immediately and without a clock edge.
REQ-032 SHALL discard in-flight operations when rst is asserted mid-pipeline; no result for them SHALL appear after rst is released.
REQ-033 SHALL accept a new operand set on the first rising edge after rst is deasserted.

Verification
REQ-034 SHALL cover subtract: op_sub=1, a=0x40400000, b=0x3F800000, out_ready=1 -> out=0x40000000 exactly 4 cycles later, flags=0.
REQ-035 SHALL cover equal operands: op_sub=1, a=b=0x3F800000 -> out=0x00000000; add 0xBF800000+0x3F800000 -> out=0x00000000.
REQ-036 SHALL cover the rounding tie: op_sub=0, a=0x3F800000, b=0x33800000 -> out=0x3F800000 with inexact=1; b=0x33C00000 -> out=0x3F800001 with inexact=1.
REQ-037 SHALL cover special values:
- 0x7F7FFFFF+0x7F7FFFFF -> out=0x7F800000, overflow=1, inexact=1.
- 0x7F800000-0x7F800000 -> out=0x7FC00000, invalid=1.
REQ-038 SHALL cover backpressure: stream 8 operations with out_ready toggled 1/0 each cycle -> all 8 results in order, none lost or duplicated, out stable while stalled, in_ready=0 only when stalled.
REQ-039 SHALL cover reset mid-operation: assert rst 2 cycles after issuing 3 operations -> out_valid=0 immediately, and no stale result appears after release.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// Four-stage pipelined floating-point adder/subtractor with round-to-nearest-even,
// subnormals flushed to signed zero, and a global stall driven by output backpressure.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op_sub,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out,
  output logic [3:0]           flags
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int M   = MAN_W + 1;
  localparam int X   = MAN_W + 4;
  localparam int E2  = EXP_W + 2;
  localparam int LZW = $clog2(X + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] SH_MAX   = EXP_W'(MAN_W + 3);
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic         spec;
    logic [W-1:0] word;
    logic [3:0]   flg;
  } spec_t;

  typedef struct packed {
    logic             v;
    logic             sign;
    logic             sub;
    logic [EXP_W-1:0] exp;
    logic [EXP_W-1:0] diff;
    logic [M-1:0]     mbig;
    logic [M-1:0]     msml;
    spec_t            sp;
  } s1_t;

  typedef struct packed {
    logic             v;
    logic             sign;
    logic             sub;
    logic [EXP_W-1:0] exp;
    logic [X:0]       sum;
    spec_t            sp;
  } s2_t;

  typedef struct packed {
    logic          v;
    logic          sign;
    logic          zero;
    logic          tiny;
    logic [E2-1:0] exp;
    logic [X-1:0]  norm;
    spec_t         sp;
  } s3_t;

  function automatic logic [W-1:0] inf_word(input logic s);
    return {s, EXP_ONES, {MAN_W{1'b0}}};
  endfunction

  function automatic logic [LZW-1:0] lzc(input logic [X-1:0] v);
    logic [LZW-1:0] n;
    n = LZW'(X);
    for (int i = 0; i < X; i++) begin
      n = v[i] ? LZW'(X - 1 - i) : n;
    end
    return n;
  endfunction

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  logic             out_valid_d, out_valid_q;
  logic [W-1:0]     out_d, out_q;
  logic [3:0]       flags_d, flags_q;
  logic             stall;
  logic [EXP_W-1:0] ea, eb, sh;
  logic [M-1:0]     ma, mb;
  logic             sa, sb, nan_a, nan_b, inf_a, inf_b, snan;
  logic [X+MAN_W-1:0] ext;
  logic [X-1:0]     aligned;
  logic [LZW-1:0]   lz;
  logic [M:0]       rnd;
  logic [E2-1:0]    exp_r;
  logic [MAN_W-1:0] frac_r;
  logic             inexact, round_up;

  assign stall     = out_valid_q && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign flags     = flags_q;

  // S1: unpack, special-value detection, magnitude swap and exponent difference.
  always_comb begin
    sa    = a[W-1];
    sb    = b[W-1] ^ op_sub;
    ea    = a[W-2 -: EXP_W];
    eb    = b[W-2 -: EXP_W];
    ma    = (ea != {EXP_W{1'b0}}) ? {1'b1, a[MAN_W-1:0]} : {M{1'b0}};
    mb    = (eb != {EXP_W{1'b0}}) ? {1'b1, b[MAN_W-1:0]} : {M{1'b0}};
    nan_a = (ea == EXP_ONES) && (|a[MAN_W-1:0]);
    nan_b = (eb == EXP_ONES) && (|b[MAN_W-1:0]);
    inf_a = (ea == EXP_ONES) && !(|a[MAN_W-1:0]);
    inf_b = (eb == EXP_ONES) && !(|b[MAN_W-1:0]);
    snan  = (nan_a && !a[MAN_W-1]) || (nan_b && !b[MAN_W-1]);
    s1_d.v   = in_valid;
    s1_d.sub = sa ^ sb;
    if ({ea, ma} >= {eb, mb}) begin
      s1_d.sign = sa;
      s1_d.exp  = ea;
      s1_d.diff = ea - eb;
      s1_d.mbig = ma;
      s1_d.msml = mb;
    end else begin
      s1_d.sign = sb;
      s1_d.exp  = eb;
      s1_d.diff = eb - ea;
      s1_d.mbig = mb;
      s1_d.msml = ma;
    end
    s1_d.sp.spec = 1'b1;
    s1_d.sp.word = QNAN;
    s1_d.sp.flg  = 4'b0000;
    if (nan_a || nan_b) begin
      s1_d.sp.flg = {snan, 3'b000};
    end else if (inf_a && inf_b) begin
      if (sa ^ sb) begin
        s1_d.sp.flg = 4'b1000;
      end else begin
        s1_d.sp.word = inf_word(sa);
      end
    end else if (inf_a) begin
      s1_d.sp.word = inf_word(sa);
    end else if (inf_b) begin
      s1_d.sp.word = inf_word(sb);
    end else begin
      s1_d.sp.spec = 1'b0;
    end
  end

  // S2: align the smaller mantissa (shift clamped so distant operands land in sticky), then add/subtract.
  always_comb begin
    sh      = (s1_q.diff > SH_MAX) ? SH_MAX : s1_q.diff;
    ext     = {s1_q.msml, {(MAN_W+3){1'b0}}} >> sh;
    aligned = ext[X+MAN_W-1 -: X] | {{(X-1){1'b0}}, |ext[MAN_W-1:0]};
    if (s1_q.sub) begin
      s2_d.sum = {1'b0, s1_q.mbig, 3'b000} - {1'b0, aligned};
    end else begin
      s2_d.sum = {1'b0, s1_q.mbig, 3'b000} + {1'b0, aligned};
    end
    s2_d.v    = s1_q.v;
    s2_d.sign = s1_q.sign;
    s2_d.sub  = s1_q.sub;
    s2_d.exp  = s1_q.exp;
    s2_d.sp   = s1_q.sp;
  end

  // S3: normalise on carry-out or leading zeros; an exact zero from a subtraction is +0.
  always_comb begin
    lz = lzc(s2_q.sum[X-1:0]);
    if (s2_q.sum[X]) begin
      s3_d.norm = {s2_q.sum[X:2], s2_q.sum[1] | s2_q.sum[0]};
      s3_d.exp  = {2'b00, s2_q.exp} + E2'(1'b1);
    end else begin
      s3_d.norm = s2_q.sum[X-1:0] << lz;
      s3_d.exp  = {2'b00, s2_q.exp} - E2'(lz);
    end
    s3_d.zero = (s2_q.sum == {(X+1){1'b0}});
    s3_d.tiny = !s3_d.zero && (s3_d.exp[E2-1] || (s3_d.exp == {E2{1'b0}}));
    s3_d.sign = (s3_d.zero && s2_q.sub) ? 1'b0 : s2_q.sign;
    s3_d.v    = s2_q.v;
    s3_d.sp   = s2_q.sp;
  end

  // S4: round to nearest even, renormalise on rounding carry, and select the packed result.
  always_comb begin
    inexact  = |s3_q.norm[2:0];
    round_up = s3_q.norm[2] & (s3_q.norm[1] | s3_q.norm[0] | s3_q.norm[3]);
    rnd      = {1'b0, s3_q.norm[X-1:3]} + {{M{1'b0}}, round_up};
    if (rnd[M]) begin
      exp_r  = s3_q.exp + E2'(1'b1);
      frac_r = rnd[MAN_W:1];
    end else begin
      exp_r  = s3_q.exp;
      frac_r = rnd[MAN_W-1:0];
    end
    out_valid_d = s3_q.v;
    if (s3_q.sp.spec) begin
      out_d   = s3_q.sp.word;
      flags_d = s3_q.sp.flg;
    end else if (s3_q.zero) begin
      out_d   = {s3_q.sign, {(W-1){1'b0}}};
      flags_d = 4'b0000;
    end else if (s3_q.tiny) begin
      out_d   = {s3_q.sign, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end else if (exp_r >= {2'b00, EXP_ONES}) begin
      out_d   = inf_word(s3_q.sign);
      flags_d = 4'b0101;
    end else begin
      out_d   = {s3_q.sign, exp_r[EXP_W-1:0], frac_r};
      flags_d = {3'b000, inexact};
    end
  end

  // Pipeline and output registers: cleared by reset, frozen as a whole while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= {$bits(s1_t){1'b0}};
      s2_q        <= {$bits(s2_t){1'b0}};
      s3_q        <= {$bits(s3_t){1'b0}};
      out_valid_q <= 1'b0;
      out_q       <= {W{1'b0}};
      flags_q     <= 4'b0000;
    end else if (!stall) begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
    end
  end
endmodule
